regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of writeback requesters (2..8).
REQ-002 Parameter WIDTH, default 32, data width of the register file write port.
REQ-003 Parameter AWIDTH, default 5, register address width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 clr_n  input  1  reset; asynchronous, active-low.
REQ-006 stall  input  1  when high, no requester is granted this cycle.
REQ-007 req_valid  input  NREQ  per-requester write request.
REQ-008 req_addr  input  NREQ*AWIDTH  per-requester destination register, requester i in slice [i*AWIDTH +: AWIDTH].
REQ-009 req_data  input  NREQ*WIDTH  per-requester write data, requester i in slice [i*WIDTH +: WIDTH].
REQ-010 req_ready  output  NREQ  one-hot-or-zero grant; a transfer occurs when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-011 wr_en  output  1  register file write enable, registered.
REQ-012 wr_addr  output  AWIDTH  register file write address, registered.
REQ-013 wr_data  output  WIDTH  register file write data, registered.
REQ-014 wr_src  output  clog2(NREQ)  index of the requester whose write is currently presented, registered.
REQ-015 drop_cnt  output  16  count of accepted writes to register 0.

Function
REQ-016 req_ready is combinational from req_valid, stall and the round-robin pointer rr_ptr; at most one bit is high per cycle.
REQ-017 With stall low, the grant goes to the first i with req_valid[i] high, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
REQ-018 With stall high, or no req_valid bit high, req_ready is all zero.
REQ-019 req_ready[i] does not depend on req_addr or req_data.
REQ-020 On a transfer from requester g, rr_ptr becomes (g+1) mod NREQ at that edge; with no transfer, rr_ptr holds.
REQ-021 Latency is one cycle: a transfer at edge k presents wr_addr, wr_data and wr_src = g from edge k to edge k+1.
REQ-022 wr_en is high after edge k only if a transfer occurred at edge k and its address is nonzero.
REQ-023 A transfer to address 0 drives wr_en low, still updates wr_addr, wr_data and wr_src, and increments drop_cnt.
REQ-024 drop_cnt saturates at 16'hFFFF; it does not wrap.
REQ-025 With no transfer at an edge, wr_en is 0 for the following cycle; wr_addr, wr_data and wr_src hold their last values.
REQ-026 Back-to-back transfers on consecutive cycles produce consecutive wr_en pulses, one write per cycle.
REQ-027 A requester that holds req_valid high is granted within NREQ cycles in which stall is low (starvation-free).
REQ-028 stall changes take effect in the same cycle; a write already registered in the output stage still completes.

Reset
REQ-029 While clr_n is low: rr_ptr = 0, wr_en = 0, wr_addr = 0, wr_data = 0, wr_src = 0, drop_cnt = 0, and req_ready is all zero.
REQ-030 Assertion of clr_n mid-operation discards any registered write immediately (wr_en low without waiting for clk).
REQ-031 After clr_n deasserts, the first transfer can occur on the first rising edge.

Structure
REQ-032 The shared package holds the default parameter values and the drop_cnt width constant (16).
REQ-033 Sub-module rr_pick holds the combinational round-robin priority search: inputs req and ptr, outputs one-hot grant and binary index.
REQ-034 The top level holds rr_ptr, the output stage registers and drop_cnt.

Verification
REQ-035 Single requester 2 valid, addr 7, data 32'hDEADBEEF, stall 0 -> req_ready = 4'b0100 that cycle; next cycle wr_en=1, wr_addr=7, wr_data=32'hDEADBEEF, wr_src=2.
REQ-036 All four valid continuously from reset -> grants in order 0,1,2,3,0 on five consecutive cycles, with wr_en high on each following cycle.
REQ-037 Requester 1 valid with addr 0 and data 5 -> wr_en=0, wr_data=5 next cycle, drop_cnt 0->1; drop_cnt preset near 16'hFFFF saturates.
REQ-038 stall=1 with requesters 0 and 3 valid -> req_ready=0 and rr_ptr unchanged; stall drops -> grant to requester rr_ptr-nearest.
REQ-039 clr_n pulled low while wr_en=1 and rr_ptr=2 -> wr_en, wr_addr, wr_data, drop_cnt go to 0 asynchronously; after release the first grant goes to requester 0.
REQ-040 Random valid patterns over 10k cycles -> at most one ready bit per cycle, every held request is granted within 4 unstalled cycles, and the wr_* sequence matches a reference queue model.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared defaults and widths for the register file write arbiter
package regfile_write_arbiter_pkg;

    localparam int RWA_NREQ_DEF   = 4;
    localparam int RWA_WIDTH_DEF  = 32;
    localparam int RWA_AWIDTH_DEF = 5;
    localparam int DROP_CNT_W     = 16;

    // Index width that stays legal even for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rtl/regfile_write_arbiter_rr_pick.sv - combinational round-robin search starting at ptr
module rr_pick
    import regfile_write_arbiter_pkg::*;
#(
    parameter int N  = RWA_NREQ_DEF,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW:0]   w_pos;
    logic [IW-1:0] w_sel;
    logic          w_found;

    // Walk ptr, ptr+1, ... wrapping at N; the first requester seen wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_pos   = '0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            w_sel = w_pos[IW-1:0];
            if (!w_found && req[w_sel]) begin
                w_found     = 1'b1;
                grant[w_sel] = 1'b1;
                idx         = w_sel;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter funnelling writeback requesters into one register file port
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ   = RWA_NREQ_DEF,
    parameter int WIDTH  = RWA_WIDTH_DEF,
    parameter int AWIDTH = RWA_AWIDTH_DEF,
    localparam int SW    = idx_width(NREQ)
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    stall,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*AWIDTH-1:0]  req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    wr_en,
    output logic [AWIDTH-1:0]       wr_addr,
    output logic [WIDTH-1:0]        wr_data,
    output logic [SW-1:0]           wr_src,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    logic [NREQ-1:0]       w_req;
    logic [NREQ-1:0]       w_grant;
    logic [SW-1:0]         w_idx;
    logic [SW-1:0]         w_ptr_next;
    logic                  w_xfer;
    logic [AWIDTH-1:0]     w_sel_addr;
    logic [WIDTH-1:0]      w_sel_data;

    logic [SW-1:0]         r_rr_ptr;
    logic                  r_wr_en;
    logic [AWIDTH-1:0]     r_wr_addr;
    logic [WIDTH-1:0]      r_wr_data;
    logic [SW-1:0]         r_wr_src;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // Grants are masked during reset and stall so the search never sees them.
    always_comb begin
        w_req = '0;
        if (clr_n && !stall) begin
            w_req = req_valid;
        end
    end

    rr_pick #(
        .N  (NREQ),
        .IW (SW)
    ) u_rr_pick (
        .req   (w_req),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;

    // Grant is one-hot, so an OR-mux picks the winning payload.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | req_addr[i*AWIDTH +: AWIDTH];
                w_sel_data = w_sel_data | req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_ptr_next = w_idx + 1'b1;
        if (w_idx == SW'(NREQ-1)) begin
            w_ptr_next = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_src  <= '0;
        end else if (w_xfer) begin
            r_wr_en   <= |w_sel_addr;
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
            r_wr_src  <= w_idx;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Writes to register 0 are swallowed but counted, saturating at all-ones.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_drop_cnt <= '0;
        end else if (w_xfer && (w_sel_addr == '0) && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign wr_src   = r_wr_src;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 5;

    logic            clk;
    logic            clr_n;
    logic            stall;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [W-1:0]    wr_data;
    logic [1:0]      wr_src;
    logic [15:0]     drop_cnt;

    regfile_write_arbiter #(.NREQ(N), .WIDTH(W), .AWIDTH(AW)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_src    (wr_src),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [3:0]  valid;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_src;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  src;
    } wr_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [4:0]  a_addr [N];
    logic [31:0] a_data [N];
    int          m_ptr;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_src;
    logic [15:0] m_drop;
    int          waits [N];
    wr_t         exp_q [$];
    vec_t        tv [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int ptr, input logic st, input logic [3:0] v);
        if (st) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a_addr[i];
            req_data[i*W +: W]   = a_data[i];
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_src  = '0;
        m_drop = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) waits[i] = 0;
    endtask

    task automatic do_reset();
        clr_n     = 1'b0;
        stall     = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_en",    64'(wr_en),     64'h0);
        chk("rst_addr",  64'(wr_addr),   64'h0);
        chk("rst_data",  64'(wr_data),   64'h0);
        chk("rst_src",   64'(wr_src),    64'h0);
        chk("rst_drop",  64'(drop_cnt),  64'h0);
        @(negedge clk);
        #1;
        clr_n = 1'b1;
        model_reset();
    endtask

    // One cycle against the reference model; call shortly after a falling edge.
    task automatic step(input logic st, input logic [3:0] v, output int g);
        logic [3:0] er;
        wr_t        e;
        stall     = st;
        req_valid = v;
        drive_bus();
        #1;
        g  = pick(m_ptr, st, v);
        er = (g < 0) ? 4'b0 : 4'(1 << g);
        chk("ready", 64'(req_ready), 64'(er));
        if ($countones(req_ready) > 1) chk("onehot", 64'($countones(req_ready)), 64'h1);
        for (int i = 0; i < N; i++) begin
            if (v[i] && !st) begin
                waits[i]++;
                if (g == i) begin
                    chk("starve", 64'(waits[i] <= N), 64'h1);
                    waits[i] = 0;
                end
            end
        end
        @(posedge clk);
        if (g >= 0) begin
            m_en   = (a_addr[g] != 0);
            m_addr = a_addr[g];
            m_data = a_data[g];
            m_src  = 2'(g);
            m_ptr  = (g + 1) % N;
            if (a_addr[g] == 0) begin
                if (m_drop != 16'hFFFF) m_drop++;
            end else begin
                exp_q.push_back('{a_addr[g], a_data[g], 2'(g)});
            end
        end else begin
            m_en = 1'b0;
        end
        #1;
        chk("wr_en",    64'(wr_en),    64'(m_en));
        chk("wr_addr",  64'(wr_addr),  64'(m_addr));
        chk("wr_data",  64'(wr_data),  64'(m_data));
        chk("wr_src",   64'(wr_src),   64'(m_src));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("queue_empty", 64'h1, 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk("queue_write", {25'h0, wr_addr, wr_data, wr_src}, {25'h0, e.addr, e.data, e.src});
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        int   g;
        logic held [N];

        clr_n     = 1'b0;
        stall     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0;
            a_data[i] = '0;
            held[i]   = 1'b0;
        end

        tv[0] = '{1'b0, 4'b0100, 5'd7, 32'hDEADBEEF, 4'b0100, 1'b1, 5'd7, 32'hDEADBEEF, 2'd2};
        tv[1] = '{1'b0, 4'b1111, 5'd3, 32'h1,        4'b1000, 1'b1, 5'd3, 32'h1,        2'd3};
        tv[2] = '{1'b0, 4'b1111, 5'd4, 32'h2,        4'b0001, 1'b1, 5'd4, 32'h2,        2'd0};
        tv[3] = '{1'b1, 4'b1001, 5'd8, 32'h7,        4'b0000, 1'b0, 5'd4, 32'h2,        2'd0};
        tv[4] = '{1'b0, 4'b1001, 5'd9, 32'h3,        4'b1000, 1'b1, 5'd9, 32'h3,        2'd3};
        tv[5] = '{1'b0, 4'b0000, 5'd1, 32'h4,        4'b0000, 1'b0, 5'd9, 32'h3,        2'd3};
        tv[6] = '{1'b0, 4'b0011, 5'd0, 32'h6,        4'b0001, 1'b0, 5'd0, 32'h6,        2'd0};

        do_reset();
        for (int n = 0; n < 7; n++) begin
            stall     = tv[n].stall;
            req_valid = tv[n].valid;
            for (int i = 0; i < N; i++) begin
                a_addr[i] = tv[n].addr;
                a_data[i] = tv[n].data;
            end
            drive_bus();
            #1;
            chk("tbl_ready", 64'(req_ready), 64'(tv[n].exp_ready));
            @(posedge clk);
            #1;
            chk("tbl_en",   64'(wr_en),   64'(tv[n].exp_en));
            chk("tbl_addr", 64'(wr_addr), 64'(tv[n].exp_addr));
            chk("tbl_data", 64'(wr_data), 64'(tv[n].exp_data));
            chk("tbl_src",  64'(wr_src),  64'(tv[n].exp_src));
            @(negedge clk);
            #1;
        end

        // All four held valid from reset: grants rotate 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_addr[i] = 5'(i + 10);
            a_data[i] = 32'h100 + 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b1111, g);
            chk("rotate_grant", 64'(g), 64'(k % N));
            chk("rotate_en", 64'(wr_en), 64'h1);
        end

        // Write to register 0 is dropped and counted, then drive the counter into saturation.
        do_reset();
        a_addr[1] = 5'd0;
        a_data[1] = 32'd5;
        step(1'b0, 4'b0010, g);
        chk("drop_en",   64'(wr_en),    64'h0);
        chk("drop_data", 64'(wr_data),  64'h5);
        chk("drop_one",  64'(drop_cnt), 64'h1);
        for (int i = 0; i < N; i++) begin
            a_addr[i] = 5'd0;
            a_data[i] = $urandom;
        end
        for (int k = 0; k < 65540; k++) begin
            step(1'b0, 4'b1111, g);
        end
        chk("drop_sat", 64'(drop_cnt), 64'hFFFF);

        // Asynchronous clear while a write is presented and rr_ptr is 2.
        do_reset();
        a_addr[0] = 5'd0;
        a_addr[1] = 5'd5;
        a_data[1] = 32'hCAFE;
        step(1'b0, 4'b0001, g);
        step(1'b0, 4'b0010, g);
        chk("pre_clr_en", 64'(wr_en), 64'h1);
        req_valid = 4'b1111;
        clr_n     = 1'b0;
        #1;
        chk("aclr_en",    64'(wr_en),     64'h0);
        chk("aclr_addr",  64'(wr_addr),   64'h0);
        chk("aclr_data",  64'(wr_data),   64'h0);
        chk("aclr_drop",  64'(drop_cnt),  64'h0);
        chk("aclr_ready", 64'(req_ready), 64'h0);
        #1;
        clr_n = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) a_addr[i] = 5'(i + 1);
        step(1'b0, 4'b1111, g);
        chk("post_clr_grant", 64'(g), 64'h0);

        // Random held requests with random stalls.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            logic [3:0] v;
            for (int i = 0; i < N; i++) begin
                if (!held[i] && ($urandom % 3 == 0)) begin
                    held[i]   = 1'b1;
                    a_addr[i] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
                    a_data[i] = $urandom;
                end
                v[i] = held[i];
            end
            step(($urandom % 4) == 0, v, g);
            if (g >= 0) held[g] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
